// File: rtl/mem_writer.sv
// Byte-serial store unit: takes a byte, half or word store from the memory
// stage and writes it to an 8-bit memory bus one byte per granted cycle,
// little-endian, lowest address first.
module mem_writer #(
    parameter logic [31:0] IDLE_ADDR = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  width_i,
    input  logic        bus_gnt_i,
    output logic        bus_req_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_GNT,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] data_q,  data_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  idx_q,   idx_d;
    logic        err_q,   err_d;

    logic        write_slot;

    // State and store latches; everything holds unless ready is high.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            count_q <= 3'd0;
            idx_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept stores in IDLE, step one byte per granted cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        idx_d   = idx_q;
        err_d   = err_q;

        if (rdy_in) begin
            err_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        if (width_i == 2'b11) begin
                            err_d = 1'b1;
                        end else begin
                            addr_d  = addr_i;
                            data_d  = data_i;
                            count_d = 3'd1 << width_i;
                            idx_d   = 2'd0;
                            state_d = ST_WAIT_GNT;
                        end
                    end
                end
                ST_WAIT_GNT: begin
                    if (bus_gnt_i) begin
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bus_gnt_i) begin
                        if ({1'b0, idx_q} == (count_q - 3'd1)) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Bus and status outputs; the write strobe is gated by ready directly.
    always_comb begin
        write_slot = (state_q == ST_WRITE) && bus_gnt_i;
        mem_wr     = write_slot && rdy_in;
        mem_a      = IDLE_ADDR;
        mem_dout   = 8'h00;
        if (write_slot) begin
            mem_a    = addr_q + {30'b0, idx_q};
            mem_dout = data_q[{idx_q, 3'b000} +: 8];
        end
        busy_o    = (state_q == ST_WAIT_GNT) || (state_q == ST_WRITE);
        bus_req_o = busy_o;
        done_o    = (state_q == ST_DONE);
        err_o     = err_q;
    end

endmodule

// File: tb/tb_mem_writer.sv
// Self-checking bench for mem_writer: a queue-based model of pending bytes
// is compared against the DUT on every cycle, with directed stores pinned by
// literal write logs followed by a randomized run.
module tb_mem_writer;

    localparam logic [31:0] IA = 32'hDEAD_BEE0;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        req_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [1:0]  width_i;
    logic        bus_gnt_i;
    logic        bus_req_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;

    int checks;
    int errors;

    // Model: phase 0 idle, 1 waiting for grant, 2 writing, 3 done.
    int         m_phase;
    bit         m_err;
    bit [39:0]  m_q[$];

    // Observed writes and pulses taken from the DUT bus.
    bit [39:0]  wlog[$];
    int         done_cnt;
    int         err_cnt;

    mem_writer #(.IDLE_ADDR(IA)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .width_i   (width_i),
        .bus_gnt_i (bus_gnt_i),
        .bus_req_o (bus_req_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .mem_a     (mem_a),
        .mem_dout  (mem_dout),
        .mem_wr    (mem_wr)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkLog(input string name, input int idx, input logic [31:0] a, input logic [7:0] d);
        if (idx < wlog.size()) begin
            checkOutput(name, wlog[idx], {a, d});
        end else begin
            checkOutput(name, 40'hFF_FFFF_FFFF, {a, d});
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] width, input logic gnt, input logic rdy);
        req_i     = req;
        addr_i    = addr;
        data_i    = data;
        width_i   = width;
        bus_gnt_i = gnt;
        rdy_in    = rdy;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic gnt);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, gnt, 1'b1);
        end
    endtask

    task automatic clearLog();
        wlog.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // Behavioural model: a store becomes a queue of (address, byte) pairs
    // that drain one per granted ready cycle.
    initial begin
        m_phase = 0;
        m_err   = 1'b0;
        forever begin
            @(posedge clk_in or negedge rst_in);
            if (!rst_in) begin
                m_phase = 0;
                m_err   = 1'b0;
                m_q.delete();
            end else if (rdy_in) begin
                m_err = (m_phase == 0) && req_i && (width_i == 2'b11);
                case (m_phase)
                    0: begin
                        if (req_i && width_i != 2'b11) begin
                            for (int i = 0; i < (1 << width_i); i++) begin
                                logic [31:0] a;
                                a = addr_i + 32'(i);
                                m_q.push_back({a, data_i[8*i +: 8]});
                            end
                            m_phase = 1;
                        end
                    end
                    1: if (bus_gnt_i) m_phase = 2;
                    2: begin
                        if (bus_gnt_i) begin
                            if (m_q.size() > 0) void'(m_q.pop_front());
                            if (m_q.size() == 0) m_phase = 3;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        forever begin
            bit slot;
            bit act;
            @(negedge clk_in);
            slot = (m_phase == 2) && bus_gnt_i;
            act  = (m_phase == 1) || (m_phase == 2);
            checkOutput("mem_wr", 40'(mem_wr), 40'(slot && rdy_in));
            if (slot && rdy_in && m_q.size() > 0) begin
                checkOutput("mem_a", 40'(mem_a), 40'(m_q[0][39:8]));
                checkOutput("mem_dout", 40'(mem_dout), 40'(m_q[0][7:0]));
            end else if (!slot) begin
                checkOutput("mem_a_idle", 40'(mem_a), 40'(IA));
                checkOutput("mem_dout_idle", 40'(mem_dout), 40'h0);
            end
            checkOutput("busy_o", 40'(busy_o), 40'(act));
            checkOutput("bus_req_o", 40'(bus_req_o), 40'(act));
            checkOutput("done_o", 40'(done_o), 40'(m_phase == 3));
            checkOutput("err_o", 40'(err_o), 40'(m_err));
            if (mem_wr) wlog.push_back({mem_a, mem_dout});
            if (done_o && rdy_in) done_cnt++;
            if (err_o && rdy_in) err_cnt++;
        end
    end

    // Directed scenarios, then a randomized run with occasional resets.
    initial begin
        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        req_i     = 1'b0;
        addr_i    = 32'h0;
        data_i    = 32'h0;
        width_i   = 2'b00;
        bus_gnt_i = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("rst_bus_req", 40'(bus_req_o), 40'h0);
        checkOutput("rst_busy", 40'(busy_o), 40'h0);
        checkOutput("rst_done", 40'(done_o), 40'h0);
        checkOutput("rst_err", 40'(err_o), 40'h0);
        checkOutput("rst_mem_wr", 40'(mem_wr), 40'h0);
        checkOutput("rst_mem_dout", 40'(mem_dout), 40'h0);
        checkOutput("rst_mem_a", 40'(mem_a), 40'hDE_ADBE_E0);
        rst_in = 1'b1;

        // Word store with grant held.
        clearLog();
        applyStimulus(1'b1, 32'h100, 32'hDDCC_BBAA, 2'b10, 1'b1, 1'b1);
        idleCycles(7, 1'b1);
        checkOutput("word_count", 40'(wlog.size()), 40'd4);
        checkLog("word_b0", 0, 32'h100, 8'hAA);
        checkLog("word_b1", 1, 32'h101, 8'hBB);
        checkLog("word_b2", 2, 32'h102, 8'hCC);
        checkLog("word_b3", 3, 32'h103, 8'hDD);
        checkOutput("word_done", 40'(done_cnt), 40'd1);

        // Byte store at an odd address.
        clearLog();
        applyStimulus(1'b1, 32'h2003, 32'hDDCC_BBAA, 2'b00, 1'b1, 1'b1);
        idleCycles(5, 1'b1);
        checkOutput("byte_count", 40'(wlog.size()), 40'd1);
        checkLog("byte_b0", 0, 32'h2003, 8'hAA);

        // Half store wrapping the address space.
        clearLog();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hDDCC_BBAA, 2'b01, 1'b1, 1'b1);
        idleCycles(6, 1'b1);
        checkOutput("half_count", 40'(wlog.size()), 40'd2);
        checkLog("half_b0", 0, 32'hFFFF_FFFF, 8'hAA);
        checkLog("half_b1", 1, 32'h0000_0000, 8'hBB);

        // Grant withdrawn for three cycles after the second byte.
        clearLog();
        applyStimulus(1'b1, 32'h300, 32'hDDCC_BBAA, 2'b10, 1'b1, 1'b1);
        idleCycles(3, 1'b1);
        idleCycles(3, 1'b0);
        idleCycles(4, 1'b1);
        checkOutput("gnt_count", 40'(wlog.size()), 40'd4);
        checkLog("gnt_b2", 2, 32'h302, 8'hCC);
        checkLog("gnt_b3", 3, 32'h303, 8'hDD);
        checkOutput("gnt_done", 40'(done_cnt), 40'd1);

        // Ready dropped for two cycles in WRITE and two in DONE.
        clearLog();
        applyStimulus(1'b1, 32'h400, 32'hDDCC_BBAA, 2'b10, 1'b1, 1'b1);
        idleCycles(2, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        idleCycles(3, 1'b1);
        applyStimulus(1'b1, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
        idleCycles(2, 1'b1);
        checkOutput("rdy_count", 40'(wlog.size()), 40'd4);
        checkLog("rdy_b1", 1, 32'h401, 8'hBB);
        checkLog("rdy_b3", 3, 32'h403, 8'hDD);
        checkOutput("rdy_done", 40'(done_cnt), 40'd1);

        // Illegal width request.
        clearLog();
        applyStimulus(1'b1, 32'h500, 32'hDDCC_BBAA, 2'b11, 1'b1, 1'b1);
        idleCycles(3, 1'b1);
        checkOutput("err_pulses", 40'(err_cnt), 40'd1);
        checkOutput("err_writes", 40'(wlog.size()), 40'd0);

        // Reset asserted after the first byte of a word store.
        clearLog();
        applyStimulus(1'b1, 32'h600, 32'h1122_3344, 2'b10, 1'b1, 1'b1);
        idleCycles(2, 1'b1);
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("rst_mid_wr", 40'(mem_wr), 40'h0);
        checkOutput("rst_mid_busy", 40'(busy_o), 40'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        applyStimulus(1'b1, 32'h700, 32'hDDCC_BBAA, 2'b00, 1'b1, 1'b1);
        idleCycles(5, 1'b1);
        checkOutput("rst_count", 40'(wlog.size()), 40'd2);
        checkLog("rst_b0", 0, 32'h600, 8'h44);
        checkLog("rst_b1", 1, 32'h700, 8'hAA);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            rst_in = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            applyStimulus(($urandom_range(0, 2) == 0), $urandom, $urandom,
                          2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 4) != 0));
        end
        rst_in = 1'b1;
        idleCycles(2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
